// File: rtl/segment_histogram.sv
// Per-segment occurrence counter over a fixed window of accepted samples.
// Rebuilds the chooser's empirical weights as WIDTH+1 bit count words.
module segment_histogram #(
  parameter int WIDTH       = 32,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_abort,
  input  logic             in_valid,
  input  logic [1:0]       in_segment_number,
  output logic [WIDTH:0]   out_count0,
  output logic [WIDTH:0]   out_count1,
  output logic [WIDTH:0]   out_count2,
  output logic [WIDTH:0]   out_count3,
  output logic             out_busy,
  output logic             out_done
);

  localparam int AW = WINDOW_LOG2 + 1;
  localparam logic [AW-1:0] LAST =
    {1'b0, {WINDOW_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] acc     [4];
  logic [AW-1:0] acc_nxt [4];
  logic [AW-1:0] cnt;
  logic          take;
  logic          last;
  logic          clear;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    take      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_start) begin
          clear     = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // abort wins over a sample arriving in the same cycle
        if (in_abort) begin
          state_nxt = IDLE;
        end else if (in_valid) begin
          take = 1'b1;
          if (cnt == LAST) begin
            last      = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_nxt[i] = acc[i] +
        AW'(take && (in_segment_number == 2'(i)));
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      cnt        <= '0;
      out_count0 <= '0;
      out_count1 <= '0;
      out_count2 <= '0;
      out_count3 <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < 4; i++) acc[i] <= '0;
        cnt <= '0;
      end else if (take) begin
        for (int i = 0; i < 4; i++) acc[i] <= acc_nxt[i];
        cnt <= cnt + 1'b1;
      end
      // final sample's increment is folded into the published counts
      if (last) begin
        out_count0 <= (WIDTH+1)'(acc_nxt[0]);
        out_count1 <= (WIDTH+1)'(acc_nxt[1]);
        out_count2 <= (WIDTH+1)'(acc_nxt[2]);
        out_count3 <= (WIDTH+1)'(acc_nxt[3]);
      end
    end
  end

  assign out_busy = (state == COLLECT);
  assign out_done = (state == DONE);

endmodule

// File: tb/tb_segment_histogram.sv
// Directed bench for segment_histogram with a window scoreboard,
// plus a long-window loopback against a modelled weighted chooser.
module tb_segment_histogram;

  localparam int WIDTH = 32;
  localparam int WL    = 2;
  localparam int WIN   = 4;

  typedef logic [3:0][WIDTH:0] cnt4_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           valid = 1'b0;
  logic [1:0]     seg = 2'd0;
  logic [WIDTH:0] c0, c1, c2, c3;
  logic           busy, done;

  logic           s_start = 1'b0;
  logic           s_valid = 1'b0;
  logic [1:0]     s_seg = 2'd0;
  logic [8:0]     s0, s1, s2, s3;
  logic           s_busy, s_done;

  int checks = 0;
  int errors = 0;

  cnt4_t sb[$];
  cnt4_t m_out;
  cnt4_t m_acc;
  int    m_st;
  int    m_cnt;
  int    busy_cyc;
  int    since_start;
  int    done_at;
  int    deck[100];

  always #5 clk = ~clk;

  segment_histogram #(.WIDTH(WIDTH), .WINDOW_LOG2(WL)) u_dut (
    .in_clock          (clk),
    .in_reset          (rst_n),
    .in_start          (start),
    .in_abort          (abort),
    .in_valid          (valid),
    .in_segment_number (seg),
    .out_count0        (c0),
    .out_count1        (c1),
    .out_count2        (c2),
    .out_count3        (c3),
    .out_busy          (busy),
    .out_done          (done)
  );

  segment_histogram #(.WIDTH(8), .WINDOW_LOG2(10)) u_stat (
    .in_clock          (clk),
    .in_reset          (rst_n),
    .in_start          (s_start),
    .in_abort          (1'b0),
    .in_valid          (s_valid),
    .in_segment_number (s_seg),
    .out_count0        (s0),
    .out_count1        (s1),
    .out_count2        (s2),
    .out_count3        (s3),
    .out_busy          (s_busy),
    .out_done          (s_done)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab,
                      input logic v, input logic [1:0] sg);
    cnt4_t got;
    start = st;
    abort = ab;
    valid = v;
    seg   = sg;
    @(posedge clk);
    case (m_st)
      0: if (st) begin
        m_acc       = '0;
        m_cnt       = 0;
        m_st        = 1;
        busy_cyc    = 0;
        since_start = -1;
        done_at     = -1;
      end
      1: if (ab) begin
        m_st = 0;
      end else if (v) begin
        m_acc[sg] = m_acc[sg] + 1;
        m_cnt++;
        if (m_cnt == WIN) begin
          sb.push_back(m_acc);
          m_st = 2;
        end
      end
      default: m_st = 0;
    endcase
    #1;
    since_start++;
    if (busy) busy_cyc++;
    check("busy", busy, m_st == 1);
    check("done", done, m_st == 2);
    if (done) begin
      done_at = since_start;
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) m_out = sb.pop_front();
    end
    got = {c3, c2, c1, c0};
    for (int i = 0; i < 4; i++)
      check($sformatf("count%0d", i), got[i], m_out[i]);
  endtask

  task automatic shuffle();
    int r, t;
    for (int j = 0; j < 100; j++) deck[j] = j;
    for (int j = 99; j > 0; j--) begin
      r = int'($urandom_range(j, 0));
      t = deck[j];
      deck[j] = deck[r];
      deck[r] = t;
    end
  endtask

  initial begin
    m_st = 0; m_cnt = 0; m_out = '0; m_acc = '0;
    busy_cyc = 0; since_start = 0; done_at = -1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_c0", c0, 0);
    check("rst_c3", c3, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 1);

    // basic window 0,1,1,3
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 3);
    check("basic_done_at", done_at, 4);
    check("basic_busy_cyc", busy_cyc, 4);
    check("basic_c0", c0, 1);
    check("basic_c1", c1, 2);
    check("basic_c2", c2, 0);
    check("basic_c3", c3, 1);
    step(0, 0, 0, 0);
    check("basic_done_1cyc", done, 0);

    // gapped valid
    step(1, 0, 0, 0);
    step(0, 0, 1, 2);
    step(0, 0, 0, 1);
    step(0, 0, 1, 2);
    step(0, 0, 0, 3);
    step(0, 0, 1, 2);
    step(0, 0, 1, 2);
    check("gap_done_at", done_at, 6);
    check("gap_c2", c2, 4);
    step(0, 0, 0, 0);

    // abort after a 1,1,1,1 window
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 2);
    step(0, 0, 1, 3);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    check("abort_c0", c0, 1);
    check("abort_c1", c1, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // start ignored in COLLECT and DONE, then back-to-back
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 1);
    step(0, 0, 1, 2);
    step(0, 0, 1, 3);
    check("ign_done_at", done_at, 4);
    check("ign_c0", c0, 1);
    step(1, 0, 1, 0);
    check("ign_done_start", busy, 0);
    step(1, 0, 0, 0);
    check("b2b_busy", busy, 1);
    repeat (4) step(0, 0, 1, 0);
    check("b2b_c0", c0, 4);
    check("b2b_c1", c1, 0);
    step(0, 0, 0, 0);

    // asynchronous reset mid-window
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    rst_n = 1'b0;
    #1;
    check("areset_c0", c0, 0);
    check("areset_c1", c1, 0);
    check("areset_busy", busy, 0);
    m_st = 0;
    m_out = '0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 2);
    check("areset_idle", busy, 0);

    // loopback: chooser weights 10,20,30,40 over 1024 samples
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    check("stat_busy", s_busy, 1);
    for (int i = 0; i < 1024; i++) begin
      if (i % 100 == 0) shuffle();
      s_valid = 1'b1;
      if (deck[i % 100] < 10)      s_seg = 2'd0;
      else if (deck[i % 100] < 30) s_seg = 2'd1;
      else if (deck[i % 100] < 60) s_seg = 2'd2;
      else                         s_seg = 2'd3;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    for (int k = 0; k < 8 && !s_done; k++) begin
      @(posedge clk);
      #1;
    end
    check("stat_done", s_done, 1);
    check("stat_sum",
          int'(s0) + int'(s1) + int'(s2) + int'(s3), 1024);
    check("stat_c0", (s0 >= 62)  && (s0 <= 142), 1);
    check("stat_c1", (s1 >= 165) && (s1 <= 245), 1);
    check("stat_c2", (s2 >= 267) && (s2 <= 347), 1);
    check("stat_c3", (s3 >= 370) && (s3 <= 450), 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
